// File: rtl/bus_sel_pkg.sv
// rtl/bus_sel_pkg.sv - shared mode encodings and width helper for the bus selector
package bus_sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Select width for an n-source bus; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_select_arbiter_rr_picker.sv
// rtl/bus_select_arbiter_rr_picker.sv - combinational round-robin winner search
//
// Ports:
//   req        in  N  request lines
//   last_grant in  W  index granted most recently; search begins one above it
//   any        out 1  at least one request is set
//   winner     out W  first requesting index after last_grant, modulo N
module rr_picker
    import bus_sel_pkg::*;
#(
    parameter  int N = 32,
    localparam int W = sel_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic         any,
    output logic [W-1:0] winner
);

    // Inputs never exceed 2N-1 here, so one conditional subtract wraps them.
    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    logic [N-1:0] rot;
    logic [W-1:0] pos;

    always_comb begin
        rot = '0;
        pos = '0;
        any = 1'b0;
        // Rotate so that bit 0 is the index just above last_grant.
        for (int i = 0; i < N; i++) begin
            rot[i] = req[wrap(int'(last_grant) + 1 + i)];
        end
        // Priority-encode: lowest set bit of the rotated vector wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = W'(i);
                any = 1'b1;
            end
        end
        // Un-rotate back to a source index.
        winner = W'(wrap(int'(last_grant) + 1 + int'(pos)));
    end

endmodule

// File: rtl/bus_select_arbiter.sv
// rtl/bus_select_arbiter.sv - registered bus source selector with direct or round-robin choice
//
// Ports:
//   clk, clr      clock and synchronous active-high reset
//   mode          0 = direct select, 1 = round-robin over req
//   select        encoded source index (direct mode)
//   sel_valid     select is meaningful this cycle (direct mode)
//   req           per-source request lines (round-robin mode)
//   data_in       flattened sources, source i at [i*WIDTH +: WIDTH]
//   bus_ready     consumer accepts bus_contents this cycle
//   bus_contents  registered bus value
//   bus_valid     bus_contents holds a fresh transfer
//   grant         one-hot index of the source in the current transfer
//   sel_err       one-cycle pulse for an out-of-range select
module bus_select_arbiter
    import bus_sel_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N_SRC = 32,
    localparam int SEL_W = sel_width(N_SRC)
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       select,
    input  logic                   sel_valid,
    input  logic [N_SRC-1:0]       req,
    input  logic [N_SRC*WIDTH-1:0] data_in,
    input  logic                   bus_ready,
    output logic [WIDTH-1:0]       bus_contents,
    output logic                   bus_valid,
    output logic [N_SRC-1:0]       grant,
    output logic                   sel_err
);

    localparam logic [SEL_W:0]     N_LIM   = (SEL_W + 1)'(N_SRC);
    localparam logic [N_SRC-1:0]   ONE_HOT = N_SRC'(1);

    logic             accept;
    logic             rr_any;
    logic [SEL_W-1:0] rr_winner;
    logic [SEL_W-1:0] last_grant;
    logic             load_en;
    logic             err_set;
    logic [SEL_W-1:0] load_idx;
    logic [WIDTH-1:0] src_data;

    // A new value may enter whenever the register is empty or being drained.
    assign accept = !bus_valid || bus_ready;

    rr_picker #(.N(N_SRC)) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .any        (rr_any),
        .winner     (rr_winner)
    );

    always_comb begin
        load_en  = 1'b0;
        err_set  = 1'b0;
        load_idx = '0;
        src_data = '0;
        if (mode == MODE_RR) begin
            load_en  = rr_any;
            load_idx = rr_winner;
        end else if (sel_valid) begin
            if ({1'b0, select} < N_LIM) begin
                load_en  = 1'b1;
                load_idx = select;
            end else begin
                err_set = 1'b1;
            end
        end
        // Explicit mux avoids out-of-range part selects for non-power-of-two N_SRC.
        for (int i = 0; i < N_SRC; i++) begin
            if (load_idx == SEL_W'(i)) begin
                src_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            bus_contents <= '0;
            bus_valid    <= 1'b0;
            grant        <= '0;
            sel_err      <= 1'b0;
            last_grant   <= SEL_W'(N_SRC - 1);
        end else begin
            sel_err <= 1'b0;
            if (accept) begin
                sel_err <= err_set;
                if (load_en) begin
                    // bus_contents is only ever written with real source data,
                    // so idle and error cycles keep the previous value.
                    bus_contents <= src_data;
                    bus_valid    <= 1'b1;
                    grant        <= ONE_HOT << load_idx;
                    if (mode == MODE_RR) begin
                        last_grant <= load_idx;
                    end
                end else begin
                    bus_valid <= 1'b0;
                    grant     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// tb/tb_bus_select_arbiter.sv - directed self-checking bench for bus_select_arbiter
module tb_bus_select_arbiter;

    localparam int W = 32;
    localparam int N = 25;
    localparam int SW = 5;

    logic           clk = 1'b0;
    logic           clr;
    logic           mode;
    logic [SW-1:0]  select;
    logic           sel_valid;
    logic [N-1:0]   req;
    logic [N*W-1:0] data_in;
    logic           bus_ready;
    logic [W-1:0]   bus_contents;
    logic           bus_valid;
    logic [N-1:0]   grant;
    logic           sel_err;

    int tests = 0;
    int errors = 0;

    bus_select_arbiter #(.WIDTH(W), .N_SRC(N)) dut (
        .clk          (clk),
        .clr          (clr),
        .mode         (mode),
        .select       (select),
        .sel_valid    (sel_valid),
        .req          (req),
        .data_in      (data_in),
        .bus_ready    (bus_ready),
        .bus_contents (bus_contents),
        .bus_valid    (bus_valid),
        .grant        (grant),
        .sel_err      (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [W-1:0] v);
        data_in[i*W +: W] = v;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] bc, input logic v,
                              input logic [N-1:0] g);
        check({tag, ".data"},  64'(bus_contents), 64'(bc));
        check({tag, ".valid"}, 64'(bus_valid),    64'(v));
        check({tag, ".grant"}, 64'(grant),        64'(g));
    endtask

    logic [N-1:0] rr_exp [5];

    initial begin
        clr = 1'b1; mode = 1'b0; select = '0; sel_valid = 1'b0;
        req = '0; bus_ready = 1'b0;
        data_in = '0;
        for (int i = 0; i < N; i++) set_src(i, 32'hA000_0000 + 32'(i));
        tick(); tick();
        expect_out("reset", 32'h0, 1'b0, '0);
        check("reset.err", 64'(sel_err), 64'h0);
        clr = 1'b0;

        // Direct select
        set_src(5, 32'hDEAD_BEEF);
        bus_ready = 1'b1; select = 5'd5; sel_valid = 1'b1;
        tick();
        expect_out("dsel", 32'hDEAD_BEEF, 1'b1, 25'h20);
        sel_valid = 1'b0;
        tick();
        expect_out("dsel_idle", 32'hDEAD_BEEF, 1'b0, '0);

        // Out-of-range select on a 25-source bus
        select = 5'd25; sel_valid = 1'b1;
        tick();
        check("oor.err", 64'(sel_err), 64'h1);
        expect_out("oor", 32'hDEAD_BEEF, 1'b0, '0);
        sel_valid = 1'b0;
        tick();
        check("oor.err_pulse", 64'(sel_err), 64'h0);

        // Stall holds everything, release loads the pending select
        set_src(3, 32'h11); set_src(7, 32'h77);
        select = 5'd3; sel_valid = 1'b1;
        tick();
        expect_out("stall_ld", 32'h11, 1'b1, 25'h8);
        bus_ready = 1'b0; select = 5'd7;
        for (int c = 0; c < 3; c++) begin
            tick();
            expect_out("stall", 32'h11, 1'b1, 25'h8);
        end
        select = 5'd25;
        tick();
        check("stall.err", 64'(sel_err), 64'h0);
        select = 5'd7; bus_ready = 1'b1;
        tick();
        expect_out("stall_rel", 32'h77, 1'b1, 25'h80);
        sel_valid = 1'b0;
        tick();

        // Round-robin fairness, pointer still at N-1 from reset
        for (int i = 0; i < 4; i++) set_src(i, 32'h100 + 32'(i));
        rr_exp[0] = 25'h1; rr_exp[1] = 25'h2; rr_exp[2] = 25'h8;
        rr_exp[3] = 25'h1; rr_exp[4] = 25'h2;
        mode = 1'b1; req = 25'b1011;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rr.grant", 64'(grant), 64'(rr_exp[c]));
            check("rr.data", 64'(bus_contents),
                  (rr_exp[c] == 25'h1) ? 64'h100 : (rr_exp[c] == 25'h2) ? 64'h101 : 64'h103);
        end

        // Wrap-around and lone requester
        set_src(24, 32'hCAFE_0024);
        req = 25'h1 << 24;
        tick();
        expect_out("rr_top", 32'hCAFE_0024, 1'b1, 25'h1 << 24);
        tick();
        expect_out("rr_lone", 32'hCAFE_0024, 1'b1, 25'h1 << 24);
        req = 25'h1;
        tick();
        expect_out("rr_wrap", 32'h100, 1'b1, 25'h1);
        req = '0;
        tick();
        expect_out("rr_none", 32'h100, 1'b0, '0);
        req = 25'b11;
        tick();
        expect_out("rr_after_none", 32'h101, 1'b1, 25'h2);

        // Reset during a stall
        req = 25'h1;
        tick();
        bus_ready = 1'b0;
        tick();
        expect_out("pre_clr", 32'h100, 1'b1, 25'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        expect_out("clr_stall", 32'h0, 1'b0, '0);
        bus_ready = 1'b1; req = '1;
        tick();
        expect_out("rr_first", 32'h100, 1'b1, 25'h1);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/bus_select_arbiter.md
Name: bus_select_arbiter

Overview:
- Parametrised, registered bus source selector for the datapath bus.
- Drives one WIDTH-bit bus from N_SRC sources, either by an encoded select or by round-robin arbitration over request lines.
- Output is a registered stage with a valid/ready handshake.
- Adds stall/hold, out-of-range select detection, a one-hot grant and non-power-of-two source counts.

Parameters:
- WIDTH, 32, bus and source data width in bits.
- N_SRC, 32, number of sources; any value 2..64.
- SEL_W, $clog2(N_SRC), select width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- mode  in  1  0 = direct select, 1 = round-robin on req.
- select  in  SEL_W  encoded source index (mode 0).
- sel_valid  in  1  select is meaningful this cycle (mode 0).
- req  in  N_SRC  per-source request lines (mode 1).
- data_in  in  N_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
- bus_ready  in  1  consumer accepts bus_contents this cycle.
- bus_contents  out  WIDTH  registered bus value.
- bus_valid  out  1  bus_contents holds a fresh transfer.
- grant  out  N_SRC  one-hot, registered; source captured into the current transfer.
- sel_err  out  1  one-cycle pulse when an out-of-range select is presented.

Behaviour:
- Reset (clr high at a clk edge, overrides everything):
  - bus_contents = 0, bus_valid = 0, grant = 0, sel_err = 0.
  - Round-robin pointer last_grant = N_SRC-1, so index 0 has first priority.
- Load condition: accept = !bus_valid || bus_ready. All capture happens only when accept = 1.
- Latency: data_in sampled at edge k appears on bus_contents after edge k, i.e. 1 cycle.
- Mode 0, on accept:
  - sel_valid = 1 and select < N_SRC: bus_contents <= source[select]; bus_valid <= 1; grant <= 1<<select; sel_err <= 0.
  - sel_valid = 1 and select >= N_SRC (possible only when N_SRC is not a power of two): bus_valid <= 0; bus_contents holds; grant <= 0; sel_err <= 1.
  - sel_valid = 0: bus_valid <= 0; bus_contents holds its last value; grant <= 0.
- Mode 1, on accept:
  - Winner = first index with req set, searching last_grant+1, last_grant+2, ... modulo N_SRC.
  - If there is a winner: capture it exactly as in mode 0; last_grant <= winner.
  - If req = 0: bus_valid <= 0; bus_contents holds; grant <= 0; last_grant unchanged.
  - select and sel_valid are ignored; sel_err <= 0.
- Stall (bus_valid = 1, bus_ready = 0):
  - bus_contents, grant and bus_valid hold exactly.
  - select, sel_valid, req and mode are ignored.
  - last_grant is unchanged; sel_err <= 0.
- Simultaneous bus_ready = 1 and a new source: old transfer completes and the new one loads at the same edge (back-to-back, full throughput).
- Mode switch: takes effect at the next accept edge. last_grant persists across mode 0 periods and is updated only by mode 1 grants.
- Wrap-around: with last_grant = N_SRC-1, the search starts at 0. A lone requester equal to last_grant is granted again.
- clr mid-stall: the transfer is dropped; the consumer sees bus_valid = 0 on the next cycle.
- bus_contents never shows X after reset: no-winner and invalid-select cases hold the old value and never load a default.

Decomposition:
- Package bus_sel_pkg:
  - MODE_DIRECT = 1'b0, MODE_RR = 1'b1.
  - A function sel_width(n) returning $clog2(n), with minimum 1.
- Sub-module rr_picker (combinational, parameter N):
  - Inputs req and last_grant.
  - Outputs any and winner index.
  - Implemented as a rotate / priority-encode / un-rotate.
- Top module owns the output register, handshake and error logic.

Test Plan:
- Direct select, N_SRC=32: mode=0, bus_ready=1, source 5 = 0xDEADBEEF, select=5, sel_valid=1 for 1 cycle → next cycle bus_contents = 0xDEADBEEF, bus_valid = 1, grant = 0x20; the following cycle bus_valid = 0 and bus_contents stays 0xDEADBEEF.
- Out of range, N_SRC=25: select=25, sel_valid=1 → sel_err = 1 for exactly one cycle; bus_valid = 0; bus_contents unchanged; grant = 0.
- Stall: load source 3 = 0x11, then bus_ready=0 for 3 cycles while select=7 → bus_contents = 0x11, grant = 0x8 and bus_valid = 1 held throughout. Raising bus_ready loads source 7 on the same edge.
- Round-robin fairness: mode=1, req=0b1011 held, bus_ready=1 → grant sequence 0x1, 0x2, 0x8, 0x1, 0x2, with the matching data captured each cycle.
- Wrap and single requester: after a grant to N_SRC-1, req = 1<<(N_SRC-1) only → granted again. Then req = 0x1 → grant = 0x1.
- Reset mid-operation: clr=1 during a stalled valid transfer → next cycle bus_contents = 0, bus_valid = 0, grant = 0. First round-robin grant with req all ones is index 0.
